// File: rtl/gups_pkg.sv
// ----------------------------------------------------------------------------
// gups_pkg
//   Shared definitions for the GUPS memory-side responder: data and counter
//   widths, the responder state encoding and the read-latency counter width.
// ----------------------------------------------------------------------------
package gups_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned CNT_W     = 32;
    // Wide enough for the largest legal read latency (8 -> wait count 0..6).
    localparam int unsigned LAT_CNT_W = 3;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRdWait,
        StRdResp,
        StWaitWr,
        StWrResp,
        StDone
    } gups_rsp_state_t;

endpackage

// File: rtl/gups_ram.sv
// ----------------------------------------------------------------------------
// gups_ram
//   Single-port synchronous RAM, 2^ADDR_BITS words x DATA_W bits. A read
//   issued with re_i at edge t appears on rdata_o after edge t+READ_LATENCY-1
//   (the first pipeline stage is the RAM output register itself). Contents
//   and pipeline are not reset; the owner rewrites the array after reset.
//
// Ports:
//   clk_i    clock
//   we_i     write enable (wdata_i -> mem[addr_i])
//   re_i     read enable  (mem[addr_i] -> pipeline stage 0)
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  read data, last pipeline stage
// ----------------------------------------------------------------------------
module gups_ram
    import gups_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] pipe_q [READ_LATENCY];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            pipe_q[0] <= mem_q[addr_i];
        end
        // Remaining stages shift every cycle; the responder only looks at the
        // tail in the one cycle where the accepted read has reached it.
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata_o = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/gups_mem_responder.sv
// ----------------------------------------------------------------------------
// gups_mem_responder
//   Memory-side responder for the GUPS update engine's req/write/ready
//   protocol. After reset it fills every word with its own index, then
//   services read-then-write update sequences and standalone writes against
//   a local RAM, pulsing ready once per completed transaction. Read and write
//   completions are counted for rate measurement.
//
//   READ_LATENCY must lie in 1..8.
//
// Ports:
//   clk        clock
//   reset      asynchronous reset, active low
//   req        transaction request, held by the engine until serviced
//   write      0 = read, 1 = write; sampled with req
//   address    word address; low ADDR_BITS index the RAM, upper bits flag oob
//   data_in    write data
//   data_out   read data, valid while ready is high after a read
//   ready      one-cycle completion pulse
//   init_done  high once the post-reset RAM fill is complete
//   oob_err    sticky out-of-range address flag, cleared only by reset
//   rd_count   completed reads (wrapping)
//   wr_count   completed writes (wrapping)
// ----------------------------------------------------------------------------
module gups_mem_responder
    import gups_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              write,
    input  logic [63:0]       address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              init_done,
    output logic              oob_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    // Last value of the wait counter before moving to the response state.
    localparam int unsigned WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    gups_rsp_state_t state_q, state_d;

    // One extra bit: the MSB sets exactly when every word has been written.
    logic [ADDR_BITS:0]    init_cnt_q, init_cnt_d;
    logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic                  oob_q, oob_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0]     dout_q, dout_d;

    logic                  addr_oob;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    assign addr_oob = |address[63:ADDR_BITS];

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: begin
                if (init_cnt_q[ADDR_BITS]) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (req) begin
                    if (write) begin
                        state_d = StWrResp;
                    end else if (READ_LATENCY > 1) begin
                        state_d = StRdWait;
                    end else begin
                        state_d = StRdResp;
                    end
                end
            end
            StRdWait: begin
                if (lat_cnt_q == LAT_CNT_W'(WAIT_LAST)) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: state_d = StWaitWr;
            StWaitWr: begin
                // Dropped req ends a read-only transaction; req with write
                // low just keeps waiting for the engine's write.
                if (!req) begin
                    state_d = StIdle;
                end else if (write) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: state_d = StDone;
            StDone: begin
                if (!req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs and RAM port mux
    // ------------------------------------------------------------------------
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = idx_q;
        ram_wdata = data_in;
        unique case (state_q)
            StInit: begin
                ram_we    = ~init_cnt_q[ADDR_BITS];
                ram_addr  = init_cnt_q[ADDR_BITS-1:0];
                ram_wdata = DATA_W'(init_cnt_q[ADDR_BITS-1:0]);
            end
            StIdle: begin
                // Upper address bits are masked; only the low index is used.
                ram_addr = address[ADDR_BITS-1:0];
                ram_we   = req & write;
                ram_re   = req & ~write;
            end
            StWaitWr: begin
                // Engine address is ignored: the write goes to the read index.
                ram_we = req & write;
            end
            default: ;
        endcase
    end

    assign ready     = (state_q == StRdResp) || (state_q == StWrResp);
    assign init_done = (state_q != StInit);
    // Read data is passed straight through while responding, then held.
    assign data_out  = (state_q == StRdResp) ? ram_rdata : dout_q;
    assign oob_err   = oob_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

    // ------------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------------
    always_comb begin
        init_cnt_d = init_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        idx_d      = idx_q;
        oob_d      = oob_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        dout_d     = dout_q;
        unique case (state_q)
            StInit: begin
                if (!init_cnt_q[ADDR_BITS]) begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                lat_cnt_d = '0;
                if (req) begin
                    idx_d = address[ADDR_BITS-1:0];
                    oob_d = oob_q | addr_oob;
                end
            end
            StRdWait: lat_cnt_d = lat_cnt_q + 1'b1;
            StRdResp: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                dout_d   = ram_rdata;
            end
            StWrResp: wr_cnt_d = wr_cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt_q <= '0;
            lat_cnt_q  <= '0;
            idx_q      <= '0;
            oob_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            dout_q     <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            idx_q      <= idx_d;
            oob_q      <= oob_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            dout_q     <= dout_d;
        end
    end

    // ------------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------------
    gups_ram #(
        .ADDR_BITS    (ADDR_BITS),
        .READ_LATENCY (READ_LATENCY)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_gups_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_gups_mem_responder
//   Directed plus randomized transactions against gups_mem_responder
//   (ADDR_BITS=4, READ_LATENCY=2), checked against a word-array model.
// ----------------------------------------------------------------------------
module tb_gups_mem_responder;

    localparam int unsigned AB    = 4;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 2 ** AB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        write = 1'b0;
    logic [63:0] address = '0;
    logic [63:0] data_in = '0;
    logic [63:0] data_out;
    logic        ready;
    logic        init_done;
    logic        oob_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    always #5 clk = ~clk;

    gups_mem_responder #(
        .ADDR_BITS    (AB),
        .READ_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .write     (write),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .ready     (ready),
        .init_done (init_done),
        .oob_err   (oob_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model
    logic [63:0] mdl_mem [DEPTH];
    int unsigned mdl_rd;
    int unsigned mdl_wr;
    logic        mdl_oob;
    logic [63:0] exp_dout;
    int          exp_pulses = 0;

    // Ready pulse monitor
    int   pulses = 0;
    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            pulses++;
            vectors++;
            assert (prev_ready === 1'b0) else begin
                miscompares++;
                $error("FAIL ready_single: observed ready high two cycles running, required one");
            end
        end
        prev_ready = ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 64'(i);
        mdl_rd   = 0;
        mdl_wr   = 0;
        mdl_oob  = 1'b0;
        exp_dout = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_rd_count"}, 64'(rd_count), 64'(mdl_rd));
        chk({tag, "_wr_count"}, 64'(wr_count), 64'(mdl_wr));
        chk({tag, "_oob_err"}, 64'(oob_err), 64'(mdl_oob));
        chk({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
    endtask

    // Reset released just after an edge: the fill spans DEPTH edges and the
    // following edge enters IDLE, so init_done appears after DEPTH+1 edges.
    task automatic wait_init();
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("init_edges", 64'(n), 64'(DEPTH + 1));
    endtask

    // Count edges until ready is seen; the first edge is the accept edge.
    task automatic wait_ready(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ready !== 1'b1 && n < 20);
        chk({tag, "_latency"}, 64'(n), 64'(exp_n));
    endtask

    // kind 0: read-only (req dropped in WAIT_WR), 1: engine read+write update,
    // 2: standalone write. hold: extra cycles req stays high after a write.
    task automatic txn(input int kind, input logic [63:0] a, input logic [63:0] w,
                       input int hold);
        logic [AB-1:0] i;
        i = a[AB-1:0];
        req     = 1'b1;
        write   = (kind == 2);
        address = a;
        data_in = (kind == 2) ? w : {$urandom, $urandom};
        if (|a[63:AB]) mdl_oob = 1'b1;
        if (kind != 2) begin
            wait_ready("rd", LAT);
            chk("rd_data", data_out, mdl_mem[i]);
            exp_dout = mdl_mem[i];
            mdl_rd++;
            exp_pulses++;
            if (kind == 0) begin
                req = 1'b0;
                tick();
                chk("rd_pulse_end", 64'(ready), 64'd0);
                tick();
                return;
            end
            tick();
            // Engine write one cycle after the read ready; its address is junk.
            write   = 1'b1;
            data_in = w;
            address = {$urandom, $urandom};
            wait_ready("upd_wr", 1);
        end else begin
            wait_ready("sw", 1);
        end
        chk("wr_dout_hold", data_out, exp_dout);
        mdl_mem[i] = w;
        mdl_wr++;
        exp_pulses++;
        for (int k = 0; k < hold; k++) tick();
        req   = 1'b0;
        write = 1'b0;
        tick();
        chk("wr_pulse_end", 64'(ready), 64'd0);
        tick();
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] w;
        logic [63:0] hi;
        int          kind;

        model_reset();
        // Reset values, with a read request already pending.
        req     = 1'b1;
        write   = 1'b0;
        address = 64'd5;
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        check_state("rst");
        reset = 1'b1;
        wait_init();
        check_state("post_init");

        // Held req from INIT is accepted in IDLE: read of 5 returns 5.
        wait_ready("held_rd", LAT);
        chk("held_rd_data", data_out, 64'd5);
        exp_dout = 64'd5;
        mdl_rd++;
        exp_pulses++;
        req = 1'b0;
        tick();
        tick();
        check_state("held_rd");

        // Engine-style update on 7, then read back.
        txn(1, 64'd7, 64'd8, 0);
        txn(0, 64'd7, 64'd0, 0);
        chk("upd7_readback", exp_dout, 64'd8);
        check_state("upd7");

        // Standalone write then read.
        txn(2, 64'd3, 64'hDEAD_BEEF, 0);
        txn(0, 64'd3, 64'd0, 0);
        chk("sw3_readback", exp_dout, 64'hDEAD_BEEF);
        check_state("sw3");

        // Out-of-range address reaches word 2 and sets the sticky flag.
        txn(0, 64'h1_0000_0002, 64'd0, 0);
        check_state("oob");
        txn(2, 64'd9, {$urandom, $urandom}, 0);
        check_state("oob_sticky");

        // req held high through DONE: no extra pulses or counts.
        txn(2, 64'd11, {$urandom, $urandom}, 5);
        check_state("held_done");

        // Read-only with req dropped in WAIT_WR leaves RAM alone.
        txn(0, 64'd12, 64'd0, 0);
        txn(0, 64'd12, 64'd0, 0);
        chk("drop_readback", exp_dout, 64'd12);
        check_state("drop");

        // Reset during RD_WAIT.
        req     = 1'b1;
        write   = 1'b0;
        address = 64'd7;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_data_out", data_out, 64'd0);
        chk("midrst_init_done", 64'(init_done), 64'd0);
        req = 1'b0;
        model_reset();
        check_state("midrst");
        tick();
        tick();
        reset = 1'b1;
        wait_init();
        txn(0, 64'd7, 64'd0, 0);
        check_state("after_midrst");

        // Randomized mix of transaction kinds and addresses.
        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 2));
            a    = 64'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 5) == 0) begin
                hi = {$urandom, $urandom};
                a  = {hi[63:AB], a[AB-1:0]};
            end
            w = {$urandom, $urandom};
            txn(kind, a, w, int'($urandom_range(0, 2)));
        end
        check_state("random");
        // Sweep every word once to compare the whole array with the model.
        for (int i = 0; i < DEPTH; i++) txn(0, 64'(i), 64'd0, 0);
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
